// File: rtl/chain_score_scheduler.sv
// rtl/chain_score_scheduler.sv - predecessor-window sequencer for the chaining score unit
// Keeps the last MAX_PRED anchors, issues one pair per cycle and keeps the best chain score.
module chain_score_scheduler #(
   parameter int MAX_PRED  = 16,
   parameter int MAX_DIST  = 5000,
   parameter int SCORE_LAT = 6,
   parameter int PW        = $clog2(MAX_PRED) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_first,
   input  logic [31:0]   in_r,
   input  logic [31:0]   in_q,
   input  logic [31:0]   in_w,
   input  logic [31:0]   avg_w,
   output logic [31:0]   sc_riX,
   output logic [31:0]   sc_riY,
   output logic [31:0]   sc_qiX,
   output logic [31:0]   sc_qiY,
   output logic [31:0]   sc_W,
   output logic [31:0]   sc_W_avg,
   input  logic [31:0]   sc_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_score,
   output logic          out_pred_valid,
   output logic [PW-1:0] out_pred_off,
   output logic          busy
);
   localparam int AW = $clog2(MAX_PRED);
   localparam logic [PW-1:0] MP_W = PW'(MAX_PRED);
   localparam logic [SCORE_LAT-1:0] EARLY_MASK = SCORE_LAT'((64'd1 << (SCORE_LAT - 1)) - 64'd1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state, state_n;

   logic [31:0]          r_i, q_i, w_i;
   logic signed [31:0]   best;
   logic                 pred_valid;
   logic [PW-1:0]        off, j_off, count;
   logic [AW-1:0]        wr_ptr;
   logic [SCORE_LAT-1:0] vld;
   logic [PW-1:0]        tag [SCORE_LAT];
   logic [31:0]          hist_r [MAX_PRED];
   logic [31:0]          hist_q [MAX_PRED];
   logic [31:0]          hist_w [MAX_PRED];
   logic signed [31:0]   hist_f [MAX_PRED];
   logic [31:0]          hold_rx, hold_ry, hold_qx, hold_qy, hold_w, hold_wavg;

   logic                 accept, issuing, in_window, ret_valid, drained;
   logic [AW-1:0]        idx_j, ret_idx;
   logic [32:0]          diff;
   logic signed [31:0]   cand;

   assign accept    = in_valid && in_ready;
   assign idx_j     = wr_ptr - j_off[AW-1:0];
   // r_j > r_i borrows into bit 32 and counts as distance 0
   assign diff      = {1'b0, r_i} - {1'b0, hist_r[idx_j]};
   assign in_window = (j_off <= count) && (diff[32] || (diff[31:0] <= 32'(MAX_DIST)));
   assign issuing   = (state == ISSUE) && in_window;
   assign ret_valid = vld[SCORE_LAT-1];
   assign ret_idx   = wr_ptr - tag[SCORE_LAT-1][AW-1:0];
   assign cand      = hist_f[ret_idx] + $signed(sc_result);
   // the last stage is consumed this cycle, so only earlier stages hold us back
   assign drained   = (vld & EARLY_MASK) == '0;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = ISSUE;
         ISSUE:   if (!in_window) state_n = drained ? DONE : DRAIN;
         DRAIN:   if (drained) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         wr_ptr     <= '0;
         vld        <= '0;
         r_i        <= '0;
         q_i        <= '0;
         w_i        <= '0;
         best       <= '0;
         pred_valid <= 1'b0;
         off        <= '0;
         j_off      <= '0;
         hold_rx    <= '0;
         hold_ry    <= '0;
         hold_qx    <= '0;
         hold_qy    <= '0;
         hold_w     <= '0;
         hold_wavg  <= '0;
      end else begin
         state <= state_n;
         vld   <= SCORE_LAT'({vld, issuing});
         if (accept) begin
            r_i        <= in_r;
            q_i        <= in_q;
            w_i        <= in_w;
            best       <= $signed(in_w);
            pred_valid <= 1'b0;
            off        <= '0;
            j_off      <= PW'(1);
            if (in_first) count <= '0;
         end
         if (issuing) begin
            j_off     <= j_off + PW'(1);
            hold_rx   <= r_i;
            hold_ry   <= hist_r[idx_j];
            hold_qx   <= q_i;
            hold_qy   <= hist_q[idx_j];
            hold_w    <= w_i;
            hold_wavg <= avg_w;
         end
         // strict compare keeps the nearer predecessor on ties
         if (ret_valid && (cand > best)) begin
            best       <= cand;
            pred_valid <= 1'b1;
            off        <= tag[SCORE_LAT-1];
         end
         if ((state == DONE) && out_ready) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != MP_W) count <= count + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = SCORE_LAT - 1; i > 0; i--) tag[i] <= tag[i-1];
      tag[0] <= j_off;
      if (!reset && (state == DONE) && out_ready) begin
         hist_r[wr_ptr] <= r_i;
         hist_q[wr_ptr] <= q_i;
         hist_w[wr_ptr] <= w_i;
         hist_f[wr_ptr] <= best;
      end
   end

   assign sc_riX   = issuing ? r_i           : hold_rx;
   assign sc_riY   = issuing ? hist_r[idx_j] : hold_ry;
   assign sc_qiX   = issuing ? q_i           : hold_qx;
   assign sc_qiY   = issuing ? hist_q[idx_j] : hold_qy;
   assign sc_W     = issuing ? w_i           : hold_w;
   assign sc_W_avg = issuing ? avg_w         : hold_wavg;

   assign in_ready       = (state == IDLE) && !reset;
   assign out_valid      = (state == DONE);
   assign out_score      = best;
   assign out_pred_valid = pred_valid;
   assign out_pred_off   = off;
   assign busy           = (state != IDLE);
endmodule

// File: tb/tb_chain_score_scheduler.sv
// tb/tb_chain_score_scheduler.sv - scoreboard bench for chain_score_scheduler
// Constant-result score model with SCORE_LAT pipeline; expected chain results queued per anchor.
module tb_chain_score_scheduler;
   localparam int MAX_PRED  = 16;
   localparam int SCORE_LAT = 6;
   localparam int PW        = $clog2(MAX_PRED) + 1;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_first, out_ready;
   logic [31:0]   in_r, in_q, in_w, avg_w, sc_result;
   logic          in_ready, out_valid, out_pred_valid, busy;
   logic [31:0]   sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg, out_score;
   logic [PW-1:0] out_pred_off;

   int vectors     = 0;
   int miscompares = 0;
   int const_val   = 10;
   logic [31:0] pipe [SCORE_LAT];

   typedef struct {
      int score;
      bit pv;
      int off;
      int lat;
   } exp_t;
   exp_t sb[$];
   logic [31:0] hist_r[$];
   logic [31:0] hist_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pipe[0] <= 32'(const_val);
      for (int i = 1; i < SCORE_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sc_result = pipe[SCORE_LAT-1];

   chain_score_scheduler #(.MAX_PRED(MAX_PRED), .MAX_DIST(5000), .SCORE_LAT(SCORE_LAT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
      .in_r(in_r), .in_q(in_q), .in_w(in_w), .avg_w(avg_w),
      .sc_riX(sc_riX), .sc_riY(sc_riY), .sc_qiX(sc_qiX), .sc_qiY(sc_qiY),
      .sc_W(sc_W), .sc_W_avg(sc_W_avg), .sc_result(sc_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score),
      .out_pred_valid(out_pred_valid), .out_pred_off(out_pred_off), .busy(busy)
   );

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_score(input int v);
      const_val = v;
      idle(SCORE_LAT + 2);
   endtask

   task automatic send_anchor(input bit first, input logic [31:0] r, input logic [31:0] q,
                              input logic [31:0] w, input int k, input int score,
                              input int off, input int hold);
      exp_t e, ex;
      int n, c;
      bit seen;
      e.score = score;
      e.pv    = (off != 0);
      e.off   = off;
      e.lat   = (k == 0) ? 2 : k + SCORE_LAT + 1;
      sb.push_back(e);
      if (first) begin
         hist_r.delete();
         hist_q.delete();
      end
      @(negedge clk);
      out_ready = (hold == 0);
      in_valid = 1'b1; in_first = first; in_r = r; in_q = q; in_w = w;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept r=%0d: in_ready=%b after %0d cycles, want 1", r, in_ready, n);
      end
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0;
      c = 1;
      seen = 1'b0;
      while (!seen && c <= 60) begin
         if (c <= k && c <= hist_r.size()) begin
            vectors++;
            if (sc_riX !== r || sc_qiX !== q || sc_W !== w || sc_W_avg !== avg_w ||
                sc_riY !== hist_r[hist_r.size()-c] || sc_qiY !== hist_q[hist_q.size()-c]) begin
               miscompares++;
               $display("FAIL operands r=%0d off=%0d: got riX=%0d riY=%0d qiX=%0d qiY=%0d W=%0d Wavg=%0d, want riX=%0d riY=%0d qiX=%0d qiY=%0d W=%0d Wavg=%0d",
                        r, c, sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg,
                        r, hist_r[hist_r.size()-c], q, hist_q[hist_q.size()-c], w, avg_w);
            end
         end
         if (out_valid === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            c++;
         end
      end
      ex = sb.pop_front();
      vectors++;
      if (!seen || c != ex.lat) begin
         miscompares++;
         $display("FAIL latency r=%0d: out_valid after %0d cycles (seen=%0b), want %0d", r, c, seen, ex.lat);
      end
      vectors++;
      if (out_score !== 32'(ex.score)) begin
         miscompares++;
         $display("FAIL score r=%0d: got %0d, want %0d", r, $signed(out_score), ex.score);
      end
      vectors++;
      if (out_pred_valid !== ex.pv || out_pred_off !== PW'(ex.off)) begin
         miscompares++;
         $display("FAIL pred r=%0d: got valid=%b off=%0d, want valid=%b off=%0d",
                  r, out_pred_valid, out_pred_off, ex.pv, ex.off);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_score !== 32'(ex.score) ||
             out_pred_off !== PW'(ex.off)) begin
            miscompares++;
            $display("FAIL hold r=%0d cycle %0d: got valid=%b ready=%b score=%0d off=%0d, want 1 0 %0d %0d",
                     r, i, out_valid, in_ready, $signed(out_score), out_pred_off, ex.score, ex.off);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL handshake r=%0d: got out_valid=%b in_ready=%b, want 0 1", r, out_valid, in_ready);
      end
      hist_r.push_back(r);
      hist_q.push_back(q);
      if (hist_r.size() > MAX_PRED) begin
         void'(hist_r.pop_front());
         void'(hist_q.pop_front());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(2);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_score !== 32'd0 || out_pred_valid !== 1'b0 ||
          out_pred_off !== '0 || busy !== 1'b0 || sc_riX !== 32'd0 || sc_riY !== 32'd0 || sc_W_avg !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: ready=%b valid=%b score=%0d pv=%b off=%0d busy=%b riX=%0d riY=%0d wavg=%0d, want all 0",
                  in_ready, out_valid, out_score, out_pred_valid, out_pred_off, busy, sc_riX, sc_riY, sc_W_avg);
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_single_issue();
      send_anchor(1'b1, 32'd100, 32'd50, 32'd15, 0, 15, 0, 0);
      send_anchor(1'b0, 32'd130, 32'd70, 32'd15, 1, 25, 1, 0);
   endtask

   task automatic test_distance_cut();
      send_anchor(1'b0, 32'd6000, 32'd80, 32'd15, 0, 15, 0, 0);
   endtask

   task automatic test_window();
      set_score(1);
      for (int k = 0; k < 20; k++)
         send_anchor(k == 0, 32'(100 + 50 * k), 32'(10 * k), 32'd10,
                     (k < MAX_PRED) ? k : MAX_PRED, 10 + k, (k > 0) ? 1 : 0, 0);
   endtask

   task automatic test_tie_negative();
      set_score(-20);
      send_anchor(1'b1, 32'd100, 32'd0, 32'd15, 0, 15, 0, 0);
      send_anchor(1'b0, 32'd200, 32'd10, 32'd15, 1, 15, 0, 0);
      set_score(10);
      send_anchor(1'b0, 32'd300, 32'd20, 32'd10, 2, 25, 1, 0);
   endtask

   task automatic test_backpressure();
      send_anchor(1'b0, 32'd400, 32'd30, 32'd5, 3, 35, 1, 10);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_first = 1'b0; in_r = 32'd500; in_q = 32'd40; in_w = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_busy: busy=%b, want 1", busy);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: in_ready=%b busy=%b, want 0 0", in_ready, busy);
      end
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_score !== 32'd0 || out_pred_valid !== 1'b0 ||
          out_pred_off !== '0 || busy !== 1'b0 || sc_riX !== 32'd0 || sc_riY !== 32'd0 || sc_W !== 32'd0) begin
         miscompares++;
         $display("FAIL mid_after: ready=%b valid=%b score=%0d pv=%b off=%0d busy=%b riX=%0d riY=%0d W=%0d, want 1 0 0 0 0 0 0 0 0",
                  in_ready, out_valid, out_score, out_pred_valid, out_pred_off, busy, sc_riX, sc_riY, sc_W);
      end
      begin
         bit rose = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) rose = 1'b1;
         end
         vectors++;
         if (rose) begin
            miscompares++;
            $display("FAIL mid_dropped: out_valid rose=%b after reset, want 0", rose);
         end
      end
      hist_r.delete();
      hist_q.delete();
      send_anchor(1'b1, 32'd700, 32'd60, 32'd7, 0, 7, 0, 0);
      send_anchor(1'b0, 32'd720, 32'd61, 32'd3, 1, 17, 1, 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
      in_r = '0; in_q = '0; in_w = '0; avg_w = 32'd19;
      test_reset();
      test_single_issue();
      test_distance_cut();
      test_window();
      test_tie_negative();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
